// File: rtl/uflash_pkg.sv
// Shared definitions for the uflash read cache: strobe codes, FSM encoding,
// flash word-address width and the latched request record.
package uflash_pkg;
    localparam int FADDR_W = 15;

    localparam logic [3:0] WSTRB_READ  = 4'b0000;
    localparam logic [3:0] WSTRB_PROG  = 4'b1111;
    localparam logic [3:0] WSTRB_ERASE = 4'b0001;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HIT,
        ST_FILL,
        ST_WRITE,
        ST_BYPASS,
        ST_RESP
    } state_e;

    typedef struct packed {
        logic [3:0]         wstrb;
        logic [FADDR_W-1:0] addr;
        logic [31:0]        data;
    } req_t;
endpackage

// File: rtl/uflash_rcache_if.sv
// sel/ready word bus used both on the CPU side and toward uflash.
interface uflash_rcache_if;
    import uflash_pkg::*;

    logic               sel;
    logic [3:0]         wstrb;
    logic [FADDR_W-1:0] addr;
    logic [31:0]        wdata;
    logic               ready;
    logic [31:0]        rdata;

    modport master (output sel, wstrb, addr, wdata, input ready, rdata);
    modport slave  (input sel, wstrb, addr, wdata, output ready, rdata);
endinterface

// File: rtl/uflash_rcache_tags.sv
// Valid/tag/data line store: combinational lookup, single-line fill,
// single-line invalidate and flush-all. Only the valid bits are reset.
module uflash_rcache_tags
    import uflash_pkg::*;
#(
    parameter int INDEX_BITS = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [FADDR_W-1:0]    lk_addr_i,
    output logic                  lk_hit_o,
    output logic [31:0]           lk_data_o,
    input  logic                  wr_en_i,
    input  logic [FADDR_W-1:0]    wr_addr_i,
    input  logic [31:0]           wr_data_i,
    input  logic                  inv_en_i,
    input  logic [INDEX_BITS-1:0] inv_idx_i,
    input  logic                  flush_i
);
    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = FADDR_W - INDEX_BITS;

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [31:0]      data_q [LINES];

    logic [INDEX_BITS-1:0] lk_idx, wr_idx;
    assign lk_idx = lk_addr_i[INDEX_BITS-1:0];
    assign wr_idx = wr_addr_i[INDEX_BITS-1:0];

    assign lk_hit_o  = valid_q[lk_idx] && (tag_q[lk_idx] == lk_addr_i[FADDR_W-1:INDEX_BITS]);
    assign lk_data_o = data_q[lk_idx];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
        end else if (flush_i) begin
            valid_q <= '0;
        end else begin
            if (inv_en_i) valid_q[inv_idx_i] <= 1'b0;
            if (wr_en_i)  valid_q[wr_idx]    <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            tag_q[wr_idx]  <= wr_addr_i[FADDR_W-1:INDEX_BITS];
            data_q[wr_idx] <= wr_data_i;
        end
    end
endmodule

// File: rtl/uflash_rcache.sv
// Direct-mapped word read cache in front of uflash: one-cycle read hits,
// everything else forwarded over the flash sel/ready handshake.
module uflash_rcache
    import uflash_pkg::*;
#(
    parameter int INDEX_BITS = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    uflash_rcache_if.slave   cpu,
    uflash_rcache_if.master  flash,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
);
    state_e           state_q;
    req_t             req_q;
    logic             ready_q, f_sel_q, skip_q;
    logic [31:0]      data_q;
    logic [CNT_W-1:0] hit_q, miss_q, hit_d, miss_d;

    logic        lk_hit, accept, is_read, fill_en, inv_en, flush;
    logic [31:0] lk_data;

    // skip_q masks sel for the first IDLE cycle after a response
    assign accept  = (state_q == ST_IDLE) && !skip_q && cpu.sel;
    assign is_read = (cpu.wstrb == WSTRB_READ);
    assign inv_en  = accept && (cpu.wstrb == WSTRB_PROG);
    assign flush   = accept && (cpu.wstrb == WSTRB_ERASE);
    assign fill_en = (state_q == ST_FILL) && flash.ready;

    assign hit_d  = (hit_q  == '1) ? hit_q  : hit_q  + 1'b1;
    assign miss_d = (miss_q == '1) ? miss_q : miss_q + 1'b1;

    uflash_rcache_tags #(.INDEX_BITS(INDEX_BITS)) u_tags (
        .clk       (clk),
        .reset_n   (reset_n),
        .lk_addr_i (cpu.addr),
        .lk_hit_o  (lk_hit),
        .lk_data_o (lk_data),
        .wr_en_i   (fill_en),
        .wr_addr_i (req_q.addr),
        .wr_data_i (flash.rdata),
        .inv_en_i  (inv_en),
        .inv_idx_i (cpu.addr[INDEX_BITS-1:0]),
        .flush_i   (flush)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            req_q    <= '0;
            ready_q  <= 1'b0;
            f_sel_q  <= 1'b0;
            skip_q   <= 1'b0;
            data_q   <= '0;
            hit_q    <= '0;
            miss_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    skip_q <= 1'b0;
                    if (accept) begin
                        req_q <= '{wstrb: cpu.wstrb, addr: cpu.addr, data: cpu.wdata};
                        if (is_read && lk_hit) begin
                            state_q <= ST_HIT;
                            ready_q <= 1'b1;
                            data_q  <= lk_data;
                            hit_q   <= hit_d;
                        end else begin
                            f_sel_q <= 1'b1;
                            if (is_read)
                                state_q <= ST_FILL;
                            else if (cpu.wstrb == WSTRB_PROG || cpu.wstrb == WSTRB_ERASE)
                                state_q <= ST_WRITE;
                            else
                                state_q <= ST_BYPASS;
                        end
                    end
                end
                ST_HIT, ST_RESP: begin
                    ready_q <= 1'b0;
                    skip_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: begin
                    if (flash.ready) begin
                        f_sel_q <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= ST_RESP;
                        if (state_q != ST_WRITE) data_q <= flash.rdata;
                        if (state_q == ST_FILL)  miss_q <= miss_d;
                    end
                end
            endcase
        end
    end

    assign cpu.ready   = ready_q;
    assign cpu.rdata   = data_q;
    assign flash.sel   = f_sel_q;
    assign flash.wstrb = req_q.wstrb;
    assign flash.addr  = req_q.addr;
    assign flash.wdata = req_q.data;
    assign hit_cnt     = hit_q;
    assign miss_cnt    = miss_q;
endmodule

// File: tb/tb_uflash_rcache.sv
// Directed + randomized bench for uflash_rcache against a line-address cache
// model and a sparse flash memory model kept in the bench.
module tb_uflash_rcache;
    localparam int IB    = 4;
    localparam int LINES = 1 << IB;
    localparam int CW    = 8;
    localparam int CMAX  = (1 << CW) - 1;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    logic [CW-1:0] hit_cnt, miss_cnt;

    uflash_rcache_if cpu_bus ();
    uflash_rcache_if fl_bus ();

    uflash_rcache #(.INDEX_BITS(IB), .CNT_W(CW)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .cpu      (cpu_bus),
        .flash    (fl_bus),
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // model: which full address each line holds, flash contents, counts
    bit          m_v    [LINES];
    logic [14:0] m_addr [LINES];
    logic [31:0] fmem   [logic [14:0]];
    int          m_hit = 0;
    int          m_miss = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] fread(input logic [14:0] a);
        if (fmem.exists(a)) return fmem[a];
        return {a, 17'h1B5A3};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < LINES; i++) m_v[i] = 1'b0;
        m_hit  = 0;
        m_miss = 0;
    endtask

    task automatic access(input logic [3:0] ws, input logic [14:0] a,
                          input logic [31:0] d, input int lat);
        int idx;
        bit hit;
        logic [31:0] exp;
        idx = int'(a) % LINES;
        hit = (ws == 4'b0000) && m_v[idx] && (m_addr[idx] == a);
        @(negedge clk);
        cpu_bus.sel = 1'b1; cpu_bus.wstrb = ws; cpu_bus.addr = a; cpu_bus.wdata = d;
        @(posedge clk); #1;
        if (hit) begin
            chk("hit_ready", {31'd0, cpu_bus.ready}, 32'd1);
            chk("hit_data", cpu_bus.rdata, fread(a));
            chk("hit_fsel", {31'd0, fl_bus.sel}, 32'd0);
            if (m_hit < CMAX) m_hit++;
        end else begin
            chk("fwd_fsel", {31'd0, fl_bus.sel}, 32'd1);
            chk("fwd_ready", {31'd0, cpu_bus.ready}, 32'd0);
            chk("fwd_addr", {17'd0, fl_bus.addr}, {17'd0, a});
            chk("fwd_wstrb", {28'd0, fl_bus.wstrb}, {28'd0, ws});
            chk("fwd_wdata", fl_bus.wdata, d);
            if (ws == 4'b1111) m_v[idx] = 1'b0;
            if (ws == 4'b0001) for (int i = 0; i < LINES; i++) m_v[i] = 1'b0;
            exp = fread(a);
            for (int c = 1; c < lat; c++) begin
                @(posedge clk); #1;
                chk("wait_fsel", {31'd0, fl_bus.sel}, 32'd1);
                chk("wait_ready", {31'd0, cpu_bus.ready}, 32'd0);
            end
            @(negedge clk);
            fl_bus.ready = 1'b1; fl_bus.rdata = exp;
            @(posedge clk); #1;
            fl_bus.ready = 1'b0; fl_bus.rdata = $urandom;
            chk("done_fsel", {31'd0, fl_bus.sel}, 32'd0);
            chk("done_ready", {31'd0, cpu_bus.ready}, 32'd1);
            if (ws != 4'b1111 && ws != 4'b0001) chk("done_data", cpu_bus.rdata, exp);
            if (ws == 4'b0000) begin
                m_v[idx] = 1'b1; m_addr[idx] = a;
                if (m_miss < CMAX) m_miss++;
            end
            if (ws == 4'b1111) fmem[a] = d;
            if (ws == 4'b0001)
                for (int c = 0; c < 64; c++) fmem[{a[14:6], 6'(c)}] = 32'hFFFF_FFFF;
        end
        chk("hit_cnt", {24'd0, hit_cnt}, 32'(m_hit));
        chk("miss_cnt", {24'd0, miss_cnt}, 32'(m_miss));
        // keep sel high through the masked cycle: it must not start a new access
        @(posedge clk); #1;
        cpu_bus.sel = 1'b0;
        chk("idle_fsel", {31'd0, fl_bus.sel}, 32'd0);
        chk("idle_ready", {31'd0, cpu_bus.ready}, 32'd0);
        @(posedge clk);
    endtask

    initial begin
        logic [14:0] pool [8];
        logic [3:0]  ws;
        int          r;
        cpu_bus.sel = 1'b0; cpu_bus.wstrb = '0; cpu_bus.addr = '0; cpu_bus.wdata = '0;
        fl_bus.ready = 1'b0; fl_bus.rdata = '0;
        model_reset();

        #2 reset_n = 1'b0;
        #1;
        chk("rst_ready", {31'd0, cpu_bus.ready}, 32'd0);
        chk("rst_fsel", {31'd0, fl_bus.sel}, 32'd0);
        chk("rst_data", cpu_bus.rdata, 32'd0);
        chk("rst_faddr", {17'd0, fl_bus.addr}, 32'd0);
        chk("rst_fwstrb", {28'd0, fl_bus.wstrb}, 32'd0);
        chk("rst_fdata", fl_bus.wdata, 32'd0);
        chk("rst_cnts", {hit_cnt, miss_cnt}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk);

        // cold miss, then hit
        fmem[15'h0123] = 32'hDEAD_BEEF;
        access(4'b0000, 15'h0123, 32'h0, 20);
        access(4'b0000, 15'h0123, 32'h0, 1);
        // conflict on index 3
        access(4'b0000, 15'h0013, 32'h0, 3);
        access(4'b0000, 15'h0123, 32'h0, 2);
        access(4'b0000, 15'h0123, 32'h0, 1);
        // program then read back through flash
        access(4'b1111, 15'h0123, 32'h1234_5678, 4);
        access(4'b0000, 15'h0123, 32'h0, 2);
        chk("prog_miss_cnt", {24'd0, miss_cnt}, 32'd4);
        // fill four lines, erase, all miss again
        for (int i = 0; i < 4; i++) access(4'b0000, 15'h0100 + 15'(i), 32'h0, 2);
        access(4'b0001, 15'h0040, 32'h0, 5);
        for (int i = 0; i < 4; i++) access(4'b0000, 15'h0100 + 15'(i), 32'h0, 1);
        chk("erase_miss_cnt", {24'd0, miss_cnt}, 32'd12);
        // odd strobe: forwarded twice, never cached
        access(4'b0011, 15'h0200, 32'h0, 2);
        access(4'b0011, 15'h0200, 32'h0, 2);
        access(4'b0000, 15'h0041, 32'h0, 2);
        access(4'b0000, 15'h0041, 32'h0, 1);

        // reset in the middle of a fill
        @(negedge clk);
        cpu_bus.sel = 1'b1; cpu_bus.wstrb = 4'b0000; cpu_bus.addr = 15'h0055;
        repeat (3) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        chk("abort_fsel", {31'd0, fl_bus.sel}, 32'd0);
        chk("abort_ready", {31'd0, cpu_bus.ready}, 32'd0);
        chk("abort_cnts", {hit_cnt, miss_cnt}, 32'd0);
        cpu_bus.sel = 1'b0;
        model_reset();
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk);
        access(4'b0000, 15'h0055, 32'h0, 2);
        access(4'b0000, 15'h0041, 32'h0, 2);

        // randomized mix over a small conflicting address pool
        pool = '{15'h0013, 15'h0123, 15'h0103, 15'h0045, 15'h7FF5, 15'h0200, 15'h0041, 15'h3C0A};
        for (int n = 0; n < 80; n++) begin
            r = int'($urandom_range(0, 9));
            ws = (r < 6) ? 4'b0000 : (r < 8) ? 4'b1111 : (r < 9) ? 4'b0001 : 4'b0110;
            access(ws, pool[$urandom_range(0, 7)], $urandom, int'($urandom_range(1, 6)));
        end

        // hit counter saturation
        access(4'b0000, 15'h0077, 32'h0, 1);
        for (int n = 0; n < CMAX + 3; n++) access(4'b0000, 15'h0077, 32'h0, 1);
        chk("hit_sat", {24'd0, hit_cnt}, 32'(CMAX));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uflash_rcache.md
# uflash_rcache

Direct-mapped, word-granular read cache between the CPU memory bus and `uflash`. Read hits return in one cycle. Misses, programs, erases and all other accesses are forwarded to `uflash` with its sel/ready handshake. Writes keep the cache coherent, and saturating hit/miss counters are exported for debug.

## Interface
- `INDEX_BITS`, default 4: cache holds 2^INDEX_BITS one-word lines; tag width is 15-INDEX_BITS; legal range 2..8.
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `sel` in 1: CPU request valid, held until `ready`.
- `wstrb` in 4: 0000 read, 1111 program, 0001 page erase; other values are treated as uncached.
- `addr` in 15: word address, bits 14:6 are the row and bits 5:0 the column.
- `data_i` in 32: CPU write data.
- `ready` out 1: one-cycle completion pulse.
- `data_o` out 32: read data, valid while `ready`=1.
- `f_sel` out 1: request to `uflash`.
- `f_wstrb` out 4: forwarded strobes.
- `f_addr` out 15: forwarded address.
- `f_data_o` out 32: forwarded write data.
- `f_ready` in 1: `uflash` done pulse.
- `f_data_i` in 32: `uflash` read data.
- `hit_cnt` out 16: saturating read-hit count.
- `miss_cnt` out 16: saturating read-miss count.

## Operation
- Storage per line: valid bit, tag = `addr[14:INDEX_BITS]`, data word. Index = `addr[INDEX_BITS-1:0]`.
- FSM states and behaviour:
  - IDLE: on `sel`=1, latch `wstrb`, `addr` and `data_i`. Then branch:
    - read that hits → HIT;
    - read that misses → FILL;
    - `wstrb`=1111 or 0001 → WRITE;
    - any other `wstrb` → BYPASS.
  - HIT: `ready`=1, `data_o` = line data, `hit_cnt`++, then → IDLE.
  - FILL: hold `f_sel`=1 with the latched request. On the edge where `f_ready`=1:
    - clear `f_sel`;
    - write the line (valid=1, tag, `f_data_i`);
    - register `f_data_i` into `data_o`;
    - `miss_cnt`++;
    - → RESP.
  - WRITE: forward to flash as in FILL, with no line fill.
    - 1111 clears the valid bit at the index, regardless of tag.
    - 0001 clears all valid bits.
    - Invalidation happens on entry to WRITE, not on completion.
    - On `f_ready` → RESP.
  - BYPASS: forward as a flash read. No fill and no invalidation. `f_data_i` goes to `data_o`, then → RESP.
  - RESP: `ready`=1, then → IDLE.
- `sel` is ignored in HIT and RESP and in the cycle they return to IDLE. A new request is accepted no earlier than the second cycle after `ready`.
- `f_sel` is registered and drops on the same edge `f_ready` is sampled high, so `uflash` sees `sel`=0 when it re-enters its IDLE.
- `f_wstrb`, `f_addr` and `f_data_o` are driven from the latched request and stay stable while `f_sel`=1.
- Counters saturate at 16'hFFFF and do not wrap. Bypass and write accesses count as neither hit nor miss.

## Timing
- Reset values:
  - state IDLE;
  - all valid bits 0;
  - `ready`=0, `f_sel`=0;
  - `data_o`, `f_wstrb`, `f_addr`, `f_data_o` = 0;
  - counters 0.
  - Tag and data arrays are not reset.
- Hit latency: `sel` sampled at edge N, `ready` high in cycle N+1.
- Miss latency: `f_sel` high from cycle N+1. If `f_ready` is sampled at edge M, `ready` is high in cycle M+1.
- Reset mid-FILL or mid-WRITE: aborts immediately. `f_sel` drops and no line is written (`uflash` shares `reset_n`).
- Simultaneous counter increment and saturation: the count holds at FFFF.

## Structure
- Shared package `uflash_pkg` holds:
  - strobe constants `WSTRB_READ`=0000, `WSTRB_PROG`=1111, `WSTRB_ERASE`=0001;
  - FSM state encoding (IDLE, HIT, FILL, WRITE, BYPASS, RESP);
  - flash word-address width 15.
- One natural sub-module, `uflash_rcache_tags`: the valid/tag/data arrays, with lookup, single-line write, single-line invalidate and flush-all ports.

## Test plan
- Cold read `addr`=0x0123, flash model returns 0xDEADBEEF after 20 cycles → `f_sel` rises 1 cycle after `sel`; `ready` 1 cycle after `f_ready`; `data_o`=0xDEADBEEF; `miss_cnt`=1.
- Re-read 0x0123 → `ready` in next cycle, `data_o`=0xDEADBEEF, `f_sel` stays 0, `hit_cnt`=1.
- Conflict miss: read 0x0013 (same index 3, different tag), then 0x0123 → both go to flash; `miss_cnt`=+2; the last line holds 0x0123's data.
- Program 1111 to 0x0123 with 0x12345678, then read 0x0123 → forwarded miss returns the new flash value.
- Fill 4 lines, erase 0001 at 0x0040, re-read all 4 → all miss. Also `wstrb`=0011 read is forwarded and not cached (a second identical access goes to flash again).
- Assert `reset_n`=0 in the middle of a FILL → `f_sel`=0 and `ready`=0 immediately. After release the same address misses again. Separately, preload `hit_cnt`=FFFF via 65535 hits plus one more → stays FFFF.
